// File: rtl/bounce_pkg.sv
// Shared types and constants for the bouncing up/down counter stream checker.
package bounce_pkg;

  // Tracking state of the checker.
  typedef enum logic [1:0] {
    SEARCH,
    INFER,
    VERIFY,
    LOCKED
  } state_t;

  // Direction encoding of the triangle counter.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/bounce_next_value.sv
// Successor function of the bouncing counter: from the current value and
// direction, produce the next value and the direction held after accepting it.
module bounce_next_value
  import bounce_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  output logic [WIDTH-1:0] next_value,
  output logic             next_dir
);

  localparam logic [WIDTH-1:0] MAX = '1;

  // Endpoints force the turn; interior values keep moving in dir.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    next_value = value;
    next_dir   = dir;
    if (value == '0) begin
      next_value = WIDTH'(1);
      next_dir   = DIR_UP;
    end else if (value == MAX) begin
      next_value = MAX - WIDTH'(1);
      next_dir   = DIR_DOWN;
    end else if (dir == DIR_UP) begin
      next_value = value + WIDTH'(1);
    end else begin
      next_value = value - WIDTH'(1);
    end
    // The value reached may itself be an endpoint, which fixes the direction.
    if (next_value == MAX) begin
      next_dir = DIR_DOWN;
    end else if (next_value == '0) begin
      next_dir = DIR_UP;
    end
  end

endmodule

// File: rtl/bounce_seq_checker.sv
// Receive-side checker for the bouncing counter stream: locks onto the
// triangle sequence, predicts every next value and flags deviations.
module bounce_seq_checker
  import bounce_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_value,
  input  logic                 err_clr,
  output logic                 locked,
  output logic                 dir,
  output logic [WIDTH-1:0]     expected,
  output logic                 mismatch,
  output logic                 turn,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int                 MC_W     = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0]   MAX      = '1;
  localparam logic [MC_W-1:0]    LOCK_TGT = MC_W'(LOCK_COUNT);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t             state, state_n;
  logic [WIDTH-1:0]   last, last_n;
  logic               dir_n;
  logic [MC_W-1:0]    match_cnt, match_cnt_n;
  logic               mismatch_n, turn_n;
  logic [WIDTH-1:0]   expected_n;
  logic               match_dir, match_dir_n;
  logic               hit, step_up, step_dn;
  logic [WIDTH-1:0]   pred_value;
  logic               pred_dir;

  // Direction after accepting w when no better information is available.
  function automatic logic endpoint_dir(input logic [WIDTH-1:0] w, input logic d);
    if (w == '0)       return DIR_UP;
    else if (w == MAX) return DIR_DOWN;
    else               return d;
  endfunction

  // Prediction for the sample after the one being accepted now; registered
  // so expected and the matched-direction are ready for the next sample.
  bounce_next_value #(.WIDTH(WIDTH)) u_next (
    .value      (last_n),
    .dir        (dir_n),
    .next_value (pred_value),
    .next_dir   (pred_dir)
  );

  assign hit     = (in_value == expected);
  assign step_up = (last != MAX) && (in_value == last + WIDTH'(1));
  assign step_dn = (last != '0)  && (in_value == last - WIDTH'(1));

  // Next-state, tracking registers and output pulses.
  always_comb begin
    state_n     = state;
    last_n      = last;
    dir_n       = dir;
    match_cnt_n = match_cnt;
    mismatch_n  = 1'b0;
    turn_n      = 1'b0;
    if (in_valid) begin
      last_n = in_value;
      unique case (state)
        SEARCH: begin
          state_n = INFER;
          dir_n   = endpoint_dir(in_value, dir);
        end
        INFER: begin
          if (step_up || step_dn) begin
            dir_n       = endpoint_dir(in_value, step_dn ? DIR_DOWN : DIR_UP);
            match_cnt_n = MC_W'(1);
            state_n     = (LOCK_COUNT <= 1) ? LOCKED : VERIFY;
          end else begin
            dir_n = endpoint_dir(in_value, dir);
          end
        end
        VERIFY: begin
          if (hit) begin
            dir_n       = match_dir;
            match_cnt_n = match_cnt + MC_W'(1);
            if (match_cnt_n == LOCK_TGT) state_n = LOCKED;
          end else begin
            dir_n       = endpoint_dir(in_value, dir);
            match_cnt_n = '0;
            state_n     = INFER;
          end
        end
        LOCKED: begin
          if (hit) begin
            dir_n  = match_dir;
            turn_n = (in_value == '0) || (in_value == MAX);
          end else begin
            dir_n       = endpoint_dir(in_value, dir);
            match_cnt_n = '0;
            mismatch_n  = 1'b1;
            state_n     = INFER;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
    expected_n  = (state_n == VERIFY || state_n == LOCKED) ? pred_value : '0;
    match_dir_n = pred_dir;
  end

  // Tracking state and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it sits inside the clocked branch
    // rather than in the sensitivity list.
    if (reset) begin
      state     <= SEARCH;
      last      <= '0;
      dir       <= DIR_UP;
      match_cnt <= '0;
      match_dir <= DIR_UP;
      expected  <= '0;
      locked    <= 1'b0;
      mismatch  <= 1'b0;
      turn      <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values regardless of statement order.
      state     <= state_n;
      last      <= last_n;
      dir       <= dir_n;
      match_cnt <= match_cnt_n;
      match_dir <= match_dir_n;
      expected  <= expected_n;
      locked    <= (state_n == LOCKED);
      mismatch  <= mismatch_n;
      turn      <= turn_n;
    end
  end

  // Saturating error counter; a clear coinciding with a mismatch leaves 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= mismatch_n ? ERR_CNT_W'(1) : '0;
    end else if (mismatch_n && err_count != ERR_MAX) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bounce_seq_checker.sv
// Directed bench for bounce_seq_checker (WIDTH 3, LOCK_COUNT 4, ERR_CNT_W 2).
module tb_bounce_seq_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [2:0] in_value;
  logic       err_clr;
  logic       locked;
  logic       dir;
  logic [2:0] expected;
  logic       mismatch;
  logic       turn;
  logic [1:0] err_count;

  int total = 0;
  int bad   = 0;

  bounce_seq_checker #(
    .WIDTH      (3),
    .LOCK_COUNT (4),
    .ERR_CNT_W  (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_value  (in_value),
    .err_clr   (err_clr),
    .locked    (locked),
    .dir       (dir),
    .expected  (expected),
    .mismatch  (mismatch),
    .turn      (turn),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every output; -1 skips a field.
  task automatic chk_all(input string tag, input int l, input int d, input int e,
                         input int m, input int t, input int ec);
    if (l  >= 0) chk({tag, ".locked"},    int'(locked),    l);
    if (d  >= 0) chk({tag, ".dir"},       int'(dir),       d);
    if (e  >= 0) chk({tag, ".expected"},  int'(expected),  e);
    if (m  >= 0) chk({tag, ".mismatch"},  int'(mismatch),  m);
    if (t  >= 0) chk({tag, ".turn"},      int'(turn),      t);
    if (ec >= 0) chk({tag, ".err_count"}, int'(err_count), ec);
  endtask

  task automatic feed(input int v);
    in_valid = 1'b1;
    in_value = 3'(v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_value = '0;
    err_clr  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0, 0);

    // Lock onto an ascending run, then bounce off MAX.
    feed(1); chk_all("s1", 0, 0, 0, 0, 0, 0);
    feed(2); chk_all("s2", 0, 0, 3, 0, 0, 0);
    feed(3); feed(4); chk_all("s4", 0, 0, 5, 0, 0, 0);
    feed(5); chk_all("s5_lock", 1, 0, 6, 0, 0, 0);
    feed(6); chk_all("s6", 1, 0, 7, 0, 0, 0);
    feed(7); chk_all("s7_turn", 1, 1, 6, 0, 1, 0);
    feed(6); chk_all("s6d", 1, 1, 5, 0, 0, 0);
    feed(5); chk_all("s5d", 1, 1, 4, 0, 0, 0);

    // Skip a value, then relock through 7.
    feed(3); chk_all("skip3", 0, 1, 0, 1, 0, 1);
    feed(4); chk_all("re4", 0, 0, 5, 0, 0, 1);
    feed(5); feed(6); chk_all("re6", 0, 0, 7, 0, 0, 1);
    feed(7); chk_all("re7_lock", 1, 1, 6, 0, 0, 1);

    // Descend to 0 and bounce; then repeat a value.
    for (int v = 6; v >= 1; v--) feed(v);
    chk_all("d1", 1, 1, 0, 0, 0, 1);
    feed(0); chk_all("d0_turn", 1, 0, 1, 0, 1, 1);
    feed(1); chk_all("u1", 1, 0, 2, 0, 0, 1);
    feed(1); chk_all("rep1", 0, 0, 0, 1, 0, 2);

    // Relock via 0 and stop at 4 ascending, then stall.
    feed(0); chk_all("r0", 0, 0, 1, 0, 0, 2);
    feed(1); feed(2); feed(3); chk_all("r3_lock", 1, 0, 4, 0, 0, 2);
    feed(4); chk_all("r4", 1, 0, 5, 0, 0, 2);
    for (int i = 0; i < 3; i++) begin
      idle();
      chk_all("gap", 1, 0, 5, 0, 0, 2);
    end
    feed(5); chk_all("after_gap", 1, 0, 6, 0, 0, 2);

    // Synchronous reset overrides a concurrent sample and err_clr.
    reset    = 1'b1;
    err_clr  = 1'b1;
    in_valid = 1'b1;
    in_value = 3'd2;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    err_clr  = 1'b0;
    in_valid = 1'b0;
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
    feed(3); chk_all("post_rst3", 0, 0, 0, 0, 0, 0);
    feed(4); chk_all("post_rst4", 0, 0, 5, 0, 0, 0);
    feed(5); feed(6); feed(7); chk_all("post_rst_lock", 1, 1, 6, 0, 0, 0);

    // Five mismatches with relock in between; the 2-bit counter saturates at 3.
    for (int i = 1; i <= 5; i++) begin
      feed(2);
      chk_all("sat_miss", 0, -1, 0, 1, 0, (i < 3) ? i : 3);
      feed(3); feed(4); feed(5); feed(6);
      chk_all("sat_relock", 1, 0, 7, 0, 0, -1);
    end
    chk("sat_hold", int'(err_count), 3);

    // Clear coinciding with a mismatch leaves one; a bare clear empties it.
    err_clr = 1'b1;
    feed(2); chk_all("clr_miss", 0, -1, -1, 1, 0, 1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk_all("clr_idle", 0, -1, -1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bounce_seq_checker.md
# bounce_seq_checker

Receive-side checker for the 3-bit bouncing up/down counter stream (0→MAX→0 triangle, endpoints visited once per turn). It samples a counter value stream, locks onto the sequence after a run of legal steps, predicts each next value, and flags every deviation. It sits downstream of the counter in the Week 1 counter exercises and acts as the self-checking consumer of that stream.

## Interface
- WIDTH, 3, width of the observed value; MAX = 2^WIDTH-1; WIDTH ≥ 2
- LOCK_COUNT, 4, consecutive legal steps required to assert locked; ≥ 1
- ERR_CNT_W, 8, width of the saturating error counter
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  in_value is sampled this cycle
- in_value  input  WIDTH  observed counter value
- err_clr  input  1  clears err_count
- locked  output  1  sequence tracked and verified
- dir  output  1  current tracked direction: 0 = up, 1 = down
- expected  output  WIDTH  predicted next value; 0 when not in VERIFY or LOCKED
- mismatch  output  1  one-cycle pulse: a sample while LOCKED did not match expected
- turn  output  1  one-cycle pulse: a matched sample while LOCKED equalled 0 or MAX
- err_count  output  ERR_CNT_W  saturating mismatch count

## Operation
- Successor rule: succ(0) = 1; succ(MAX) = MAX-1; otherwise v+1 if dir = 0, v-1 if dir = 1.
- Direction after accepting sample w: 0 if w = 0; 1 if w = MAX; otherwise unchanged on a match, or the step direction in INFER.
- State machine, advanced only when in_valid = 1:
  - SEARCH: capture last = w, go to INFER.
  - INFER: a legal step, meaning w = last ± 1 (from 0 only 1, from MAX only MAX-1), sets dir and last = w, sets match_cnt = 1, and goes to VERIFY. If match_cnt = 1 already reaches LOCK_COUNT, go straight to LOCKED. Otherwise last = w and the state stays INFER. No mismatch is raised.
  - VERIFY: if w = expected, increment match_cnt and set last = w; on reaching LOCK_COUNT go to LOCKED. Otherwise last = w, match_cnt = 0, go to INFER. No mismatch is raised.
  - LOCKED: if w = expected, set last = w and stay; pulse turn if w is 0 or MAX. Otherwise pulse mismatch, increment err_count (saturating at 2^ERR_CNT_W-1), set last = w, go to INFER.
- in_valid = 0: no state, last, dir or match_cnt change; mismatch and turn are 0.
- locked = 1 exactly while the state is LOCKED.
- err_clr: clears err_count. If it coincides with a mismatch, err_count becomes 1.

## Timing
- All outputs are registered; a sample accepted at edge N is reflected in the outputs after edge N.
- Reset values: locked 0, dir 0, expected 0, mismatch 0, turn 0, err_count 0; state SEARCH, match_cnt 0, last 0.
- Reset mid-operation overrides everything, including err_clr and in_valid.
- expected is valid whenever locked = 1, and refers to the next valid sample.
- mismatch and turn are never high together.

## Structure
- Shared package `bounce_pkg`:
  - state enum {SEARCH, INFER, VERIFY, LOCKED}
  - constants DIR_UP = 0, DIR_DOWN = 1
- Sub-module `bounce_next_value`: combinational successor function (value, dir → next value, next dir), parameterised by WIDTH. It is also reusable by the counter's own bench.
- match_cnt width is clog2(LOCK_COUNT+1).

## Test plan
- Reset, then feed 1,2,3,4,5,6,7,6,5 → locked rises after sample 5; turn pulses after 7; dir = 1 after 7; err_count = 0.
- While locked and descending at 6, feed 5,3,4,5,6,7 → mismatch pulse after 3; err_count = 1; locked drops; relocks after 7.
- While locked, feed 2,1,0,1 → turn pulse after 0; dir = 0; no mismatch. Then feed 1,1 → mismatch on the second 1.
- While locked at 4 ascending, hold in_valid = 0 for 3 cycles, then feed 5 → outputs hold during the gap; no mismatch; expected = 6 after 5.
- With ERR_CNT_W = 2, force 5 mismatches (relocking between) → err_count = 3 and holds. Then assert err_clr together with a mismatch → err_count = 1.
- Assert reset for 1 cycle while locked with err_count = 2 → next cycle: locked 0, err_count 0, expected 0, dir 0; the next two legal samples enter VERIFY.
